cp_inserter: RTL

//  Transmit-side cyclic-prefix inserter for the OFDM chain.
//  - Accepts time-domain OFDM symbols of N complex samples from the IFFT.
//  - Emits each symbol as CP_LEN prefix samples (its last CP_LEN samples), then all N samples.
//  - The prefix is what the receiver's N-sample delay/correlation sync path keys on.
//  - Ping-pong buffered: a new symbol loads while the previous one drains.

---
 rtl/cp_inserter_pkg.sv | 14 +
 rtl/cp_pingpong_buf.sv | 58 +++++
 rtl/cp_inserter.sv | 117 +++++++++++
 3 files changed

// File: rtl/cp_inserter_pkg.sv
// Shared OFDM definitions: sample types and the TX/RX symbol geometry defaults.
package cp_inserter_pkg;
    localparam int DATA_W      = 16;
    localparam int OFDM_N      = 256;
    localparam int OFDM_CP_LEN = 16;

    typedef logic signed [DATA_W-1:0] r_t;
    typedef struct packed {
        r_t re;
        r_t im;
    } cplx_t;

    typedef enum logic [1:0] {ST_IDLE, ST_CP, ST_BODY} rd_state_t;
endpackage

// File: rtl/cp_pingpong_buf.sv
// Two-bank symbol store: sequential write side with full flags, combinational read port.
module cp_pingpong_buf
    import cp_inserter_pkg::*;
#(
    parameter int N = OFDM_N
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  cplx_t              wr_data,
    input  logic               rd_bank,
    input  logic [$clog2(N)-1:0] rd_idx,
    input  logic               rd_release,
    output cplx_t              rd_data,
    output logic [1:0]         full
);
    localparam int CNT_W = $clog2(N);

    cplx_t              mem [2*N];
    logic               ready_en;
    logic               wr_bank;
    logic [CNT_W-1:0]   wr_cnt;
    logic [1:0]         full_nxt;
    logic               wr_fire;
    logic               wr_wrap;

    // ready_en keeps in_ready low during reset and for the first cycle after release
    assign in_ready = ready_en && !full[wr_bank];
    assign wr_fire  = in_valid && in_ready;
    assign wr_wrap  = wr_fire && (wr_cnt == CNT_W'(N-1));
    assign rd_data  = mem[{rd_bank, rd_idx}];

    // Set and release always hit different banks, so both are applied.
    always_comb begin
        full_nxt = full;
        if (rd_release) full_nxt[rd_bank] = 1'b0;
        if (wr_wrap)    full_nxt[wr_bank] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_en <= 1'b0;
            wr_bank  <= 1'b0;
            wr_cnt   <= '0;
            full     <= '0;
        end else begin
            ready_en <= 1'b1;
            full     <= full_nxt;
            if (wr_fire) wr_cnt <= wr_cnt + 1'b1;
            if (wr_wrap) wr_bank <= ~wr_bank;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire) mem[{wr_bank, wr_cnt}] <= wr_data;
    end
endmodule

// File: rtl/cp_inserter.sv
// Cyclic-prefix inserter: replays the last CP_LEN samples of each buffered symbol, then the symbol.
module cp_inserter
    import cp_inserter_pkg::*;
#(
    parameter int N      = OFDM_N,
    parameter int CP_LEN = OFDM_CP_LEN
) (
    input  logic clk,
    input  logic rst,
    input  logic in_valid,
    output logic in_ready,
    input  r_t   tx_re_in,
    input  r_t   tx_im_in,
    output logic out_valid,
    input  logic out_ready,
    output r_t   tx_re_out,
    output r_t   tx_im_out,
    output logic sym_start,
    output logic sym_last
);
    localparam int CNT_W = $clog2(N);
    localparam logic [CNT_W-1:0] CP_START = CNT_W'(N - CP_LEN);
    localparam logic [CNT_W-1:0] CP_NEXT  = CNT_W'((N - CP_LEN + 1) % N);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N - 1);

    if (N < 4 || (N & (N - 1)) != 0) begin : g_bad_n
        $fatal(1, "cp_inserter: N must be a power of two >= 4");
    end
    if (CP_LEN < 1 || CP_LEN > N - 1) begin : g_bad_cp
        $fatal(1, "cp_inserter: CP_LEN must be in 1..N-1");
    end

    rd_state_t          state;
    logic               rd_bank;
    logic [CNT_W-1:0]   rd_idx;
    logic [CNT_W-1:0]   rd_sel;
    logic [1:0]         full;
    cplx_t              rd_data;
    logic               adv;
    logic               launch;
    logic               rd_release;

    cp_pingpong_buf #(.N(N)) u_buf (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .wr_data    ('{re: tx_re_in, im: tx_im_in}),
        .rd_bank    (rd_bank),
        .rd_idx     (rd_sel),
        .rd_release (rd_release),
        .rd_data    (rd_data),
        .full       (full)
    );

    assign adv    = !out_valid || out_ready;
    assign rd_sel = (state == ST_IDLE) ? CP_START : rd_idx;
    // A new symbol starts from IDLE, or straight after the previous symbol's last sample.
    assign launch = adv && full[rd_bank] &&
                    ((state == ST_IDLE) || (state == ST_BODY && sym_last));
    assign rd_release = adv && (state == ST_BODY) && !sym_last && (rd_idx == LAST_IDX);

    // Output register stage: advances only when downstream can take a sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            rd_bank   <= 1'b0;
            rd_idx    <= '0;
            out_valid <= 1'b0;
            sym_start <= 1'b0;
            sym_last  <= 1'b0;
            tx_re_out <= '0;
            tx_im_out <= '0;
        end else if (adv) begin
            sym_start <= 1'b0;
            sym_last  <= 1'b0;
            if (launch) begin
                out_valid <= 1'b1;
                sym_start <= 1'b1;
                tx_re_out <= rd_data.re;
                tx_im_out <= rd_data.im;
                rd_idx    <= CP_NEXT;
                state     <= ST_CP;
            end else begin
                case (state)
                    ST_CP: begin
                        out_valid <= 1'b1;
                        tx_re_out <= rd_data.re;
                        tx_im_out <= rd_data.im;
                        rd_idx    <= rd_idx + 1'b1;
                        if (rd_idx == '0) state <= ST_BODY;
                    end
                    ST_BODY: begin
                        if (sym_last) begin
                            out_valid <= 1'b0;
                            state     <= ST_IDLE;
                        end else begin
                            out_valid <= 1'b1;
                            tx_re_out <= rd_data.re;
                            tx_im_out <= rd_data.im;
                            rd_idx    <= rd_idx + 1'b1;
                            if (rd_idx == LAST_IDX) begin
                                sym_last <= 1'b1;
                                rd_bank  <= ~rd_bank;
                                rd_idx   <= CP_START;
                            end
                        end
                    end
                    default: begin
                        out_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                endcase
            end
        end
    end
endmodule
